// File: rtl/bitgen_palette_if.sv
`default_nettype none
// ============================================================================
// Module   : bitgen_palette_if
// Brief    : Pixel/attribute, palette-write and colour-out bundle for
//            bitgen_palette (master = glyph fetch / CPU side, slave = generator).
// Revision : 1.0
// ============================================================================
interface bitgen_palette_if #(
    parameter int COLOR_W = 24,
    parameter int IDX_W   = 4
);
    logic               vga_blank_n;
    logic               vga_vsync_n;
    logic               pixel_en;
    logic [IDX_W-1:0]   fg_idx;
    logic [IDX_W-1:0]   bg_idx;
    logic               blink_attr;
    logic               pal_we;
    logic [IDX_W-1:0]   pal_waddr;
    logic [COLOR_W-1:0] pal_wdata;
    logic [COLOR_W-1:0] rgb;
    logic               blank_n_out;

    modport master (
        output vga_blank_n, vga_vsync_n, pixel_en, fg_idx, bg_idx, blink_attr,
        output pal_we, pal_waddr, pal_wdata,
        input  rgb, blank_n_out
    );

    modport slave (
        input  vga_blank_n, vga_vsync_n, pixel_en, fg_idx, bg_idx, blink_attr,
        input  pal_we, pal_waddr, pal_wdata,
        output rgb, blank_n_out
    );
endinterface
`default_nettype wire

// File: rtl/bitgen_palette.sv
`default_nettype none
// ============================================================================
// Module   : bitgen_palette
// Brief    : Two-stage palette-indexed pixel colour generator with keyed
//            transparency; optional frame-counter blink via BITGEN_BLINK_EN.
// Revision : 1.0
// ============================================================================
module bitgen_palette #(
    parameter int                 COLOR_W   = 24,
    parameter int                 PAL_DEPTH = 16,
    parameter int                 IDX_W     = 4,
    parameter logic [COLOR_W-1:0] KEY_COLOR = 24'h000000,
    parameter int                 BLINK_DIV = 5
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bitgen_palette_if.slave     bus
);

    logic               r_blank_s1;
    logic               r_pix_s1;
    logic [IDX_W-1:0]   r_fg_s1;
    logic [IDX_W-1:0]   r_bg_s1;
    logic [COLOR_W-1:0] r_pal [PAL_DEPTH];
    logic [COLOR_W-1:0] w_fgc;
    logic [COLOR_W-1:0] w_bgc;
    logic               w_suppress;
    logic [COLOR_W-1:0] r_rgb;
    logic               r_blank_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blank_s1 <= 1'b0;
            r_pix_s1   <= 1'b0;
            r_fg_s1    <= '0;
            r_bg_s1    <= '0;
        end else begin
            r_blank_s1 <= bus.vga_blank_n;
            r_pix_s1   <= bus.pixel_en;
            r_fg_s1    <= bus.fg_idx;
            r_bg_s1    <= bus.bg_idx;
        end
    end

    // Addresses at or beyond PAL_DEPTH match no entry, so such writes are dropped.
    generate
        for (genvar i = 0; i < PAL_DEPTH; i++) begin : g_pal
            localparam logic [COLOR_W-1:0] c_init = (i == 1) ? '1 : '0;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_pal[i] <= c_init;
                end else if (bus.pal_we && (bus.pal_waddr == IDX_W'(i))) begin
                    r_pal[i] <= bus.pal_wdata;
                end
            end
        end
    endgenerate

    // Out-of-range indices fall through to entry 0.
    always_comb begin
        w_fgc = r_pal[0];
        w_bgc = r_pal[0];
        for (int i = 1; i < PAL_DEPTH; i++) begin
            if (r_fg_s1 == IDX_W'(i)) w_fgc = r_pal[i];
            if (r_bg_s1 == IDX_W'(i)) w_bgc = r_pal[i];
        end
    end

`ifdef BITGEN_BLINK_EN
    logic                 r_vsync_prev;
    logic [BLINK_DIV-1:0] r_frame_cnt;
    logic                 r_blink_s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_prev <= 1'b1;
            r_frame_cnt  <= '0;
            r_blink_s1   <= 1'b0;
        end else begin
            r_vsync_prev <= bus.vga_vsync_n;
            r_blink_s1   <= bus.blink_attr;
            if (r_vsync_prev && !bus.vga_vsync_n) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_suppress = r_blink_s1 & r_frame_cnt[BLINK_DIV-1];
`else
    wire w_unused_blink = bus.vga_vsync_n ^ bus.blink_attr;
    assign w_suppress = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rgb       <= '0;
            r_blank_out <= 1'b0;
        end else begin
            r_blank_out <= r_blank_s1;
            if (!r_blank_s1) begin
                r_rgb <= '0;
            end else if (!r_pix_s1 || (w_fgc == KEY_COLOR) || w_suppress) begin
                r_rgb <= w_bgc;
            end else begin
                r_rgb <= w_fgc;
            end
        end
    end

    assign bus.rgb         = r_rgb;
    assign bus.blank_n_out = r_blank_out;

endmodule
`default_nettype wire

// File: tb/tb_bitgen_palette.sv
`default_nettype none
// ============================================================================
// Module   : tb_bitgen_palette
// Brief    : Directed self-checking bench for bitgen_palette (12-entry palette
//            so out-of-range index/address behaviour is reachable).
// Revision : 1.0
// ============================================================================
module tb_bitgen_palette;

    localparam int COLOR_W   = 24;
    localparam int PAL_DEPTH = 12;
    localparam int IDX_W     = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    bitgen_palette_if #(.COLOR_W(COLOR_W), .IDX_W(IDX_W)) bus ();

    bitgen_palette #(
        .COLOR_W   (COLOR_W),
        .PAL_DEPTH (PAL_DEPTH),
        .IDX_W     (IDX_W),
        .KEY_COLOR (24'h000000),
        .BLINK_DIV (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_pal(input logic [IDX_W-1:0] addr, input logic [COLOR_W-1:0] data);
        bus.pal_we    = 1'b1;
        bus.pal_waddr = addr;
        bus.pal_wdata = data;
        tick();
        bus.pal_we    = 1'b0;
    endtask

    // Drive a background-only pixel and wait out the two-stage latency.
    task automatic show_bg(input logic [IDX_W-1:0] idx);
        bus.pixel_en = 1'b0;
        bus.bg_idx   = idx;
        tick();
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset           = 1'b1;
        bus.vga_blank_n = 1'b0;
        bus.vga_vsync_n = 1'b1;
        bus.pixel_en    = 1'b0;
        bus.fg_idx      = '0;
        bus.bg_idx      = '0;
        bus.blink_attr  = 1'b0;
        bus.pal_we      = 1'b0;
        bus.pal_waddr   = '0;
        bus.pal_wdata   = '0;

        tick();
        tick();
        check("reset_rgb", 32'(bus.rgb), 32'h0);
        check("reset_blank", 32'(bus.blank_n_out), 32'h0);
        reset = 1'b0;

        // Default palette: entry 1 white, entry 0 black; latency is two edges
        bus.vga_blank_n = 1'b1;
        bus.pixel_en    = 1'b1;
        bus.fg_idx      = 4'd1;
        bus.bg_idx      = 4'd0;
        tick();
        check("lat1_rgb", 32'(bus.rgb), 32'h0);
        check("lat1_blank", 32'(bus.blank_n_out), 32'h0);
        tick();
        check("dflt_fg", 32'(bus.rgb), 32'hFFFFFF);
        check("dflt_blank", 32'(bus.blank_n_out), 32'h1);
        bus.pixel_en = 1'b0;
        tick();
        tick();
        check("dflt_bg", 32'(bus.rgb), 32'h000000);

        // Alternating fg/bg stream
        write_pal(4'd3, 24'hFF0000);
        write_pal(4'd5, 24'h00FF00);
        bus.fg_idx   = 4'd3;
        bus.bg_idx   = 4'd5;
        bus.pixel_en = 1'b1; tick();
        bus.pixel_en = 1'b0; tick();
        check("alt0", 32'(bus.rgb), 32'hFF0000);
        bus.pixel_en = 1'b1; tick();
        check("alt1", 32'(bus.rgb), 32'h00FF00);
        bus.pixel_en = 1'b0; tick();
        check("alt2", 32'(bus.rgb), 32'hFF0000);
        tick();
        check("alt3", 32'(bus.rgb), 32'h00FF00);

        // Key colour makes foreground transparent; blanking forces black
        write_pal(4'd3, 24'h000000);
        bus.pixel_en = 1'b1;
        tick();
        tick();
        check("key_fg", 32'(bus.rgb), 32'h00FF00);
        bus.vga_blank_n = 1'b0;
        tick();
        check("blank_lat_rgb", 32'(bus.rgb), 32'h00FF00);
        check("blank_lat_n", 32'(bus.blank_n_out), 32'h1);
        tick();
        check("blank_rgb", 32'(bus.rgb), 32'h0);
        check("blank_n", 32'(bus.blank_n_out), 32'h0);
        bus.vga_blank_n = 1'b1;

        // Read-before-write on entry 5
        bus.pixel_en = 1'b0;
        bus.bg_idx   = 4'd5;
        tick();
        bus.pal_we    = 1'b1;
        bus.pal_waddr = 4'd5;
        bus.pal_wdata = 24'h0000FF;
        tick();
        bus.pal_we = 1'b0;
        check("rbw_old", 32'(bus.rgb), 32'h00FF00);
        tick();
        check("rbw_new", 32'(bus.rgb), 32'h0000FF);

        // Out-of-range index reads entry 0; out-of-range write is dropped
        write_pal(4'd0, 24'h123456);
        show_bg(4'd14);
        check("oor_idx", 32'(bus.rgb), 32'h123456);
        write_pal(4'd12, 24'hABCDEF);
        show_bg(4'd0);
        check("oor_wr_e0", 32'(bus.rgb), 32'h123456);
        show_bg(4'd12);
        check("oor_wr_e12", 32'(bus.rgb), 32'h123456);
        show_bg(4'd4);
        check("oor_wr_e4", 32'(bus.rgb), 32'h000000);

        // Asynchronous reset mid-line
        write_pal(4'd3, 24'hFF0000);
        bus.pixel_en = 1'b1;
        bus.fg_idx   = 4'd3;
        bus.bg_idx   = 4'd5;
        tick();
        tick();
        check("pre_rst", 32'(bus.rgb), 32'hFF0000);
        #2;
        reset = 1'b1;
        #1;
        check("async_rgb", 32'(bus.rgb), 32'h0);
        check("async_blank", 32'(bus.blank_n_out), 32'h0);
        tick();
        reset = 1'b0;
        show_bg(4'd3);
        check("rst_pal3", 32'(bus.rgb), 32'h000000);
        show_bg(4'd1);
        check("rst_pal1", 32'(bus.rgb), 32'hFFFFFF);

`ifdef BITGEN_BLINK_EN
        // Blink: MSB of 5-bit frame counter suppresses foreground on frames 16-31
        bus.pixel_en   = 1'b1;
        bus.fg_idx     = 4'd1;
        bus.bg_idx     = 4'd0;
        bus.blink_attr = 1'b1;
        tick();
        tick();
        for (int f = 0; f <= 32; f++) begin
            check($sformatf("blink_f%0d", f), 32'(bus.rgb),
                  ((f % 32) >= 16) ? 32'h000000 : 32'hFFFFFF);
            if (f == 20) begin
                bus.blink_attr = 1'b0;
                tick();
                tick();
                check("blink_off", 32'(bus.rgb), 32'hFFFFFF);
                bus.blink_attr = 1'b1;
            end
            bus.vga_vsync_n = 1'b0;
            tick();
            bus.vga_vsync_n = 1'b1;
            tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=no_finish expected=finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
